// File: rtl/nanolada_pkg.sv
// Shared nanoLADA constants: arbiter state encoding and requester ids.
package nanolada_pkg;

    localparam logic ARB_IDLE = 1'b0;
    localparam logic ARB_BUSY = 1'b1;

    localparam logic REQ_IF  = 1'b0;
    localparam logic REQ_MEM = 1'b1;

    typedef enum logic {
        S_IDLE = ARB_IDLE,
        S_BUSY = ARB_BUSY
    } arb_state_t;

endpackage

// File: rtl/mem_arbiter2_if.sv
// Requester and memory-port signals of the two-requester arbiter.
interface mem_arbiter2_if #(
    parameter int WIDTH = 32
);
    logic             req0, req1;
    logic [WIDTH-1:0] addr0, addr1;
    logic [WIDTH-1:0] wdata0, wdata1;
    logic             we0, we1;
    logic             gnt0, gnt1;
    logic             done0, done1;
    logic [WIDTH-1:0] rdata;
    logic             timeout_err;
    logic             sel;
    logic             mem_req;
    logic             mem_we;
    logic [WIDTH-1:0] mem_addr, mem_wdata;
    logic             mem_ready;
    logic [WIDTH-1:0] mem_rdata;

    modport master (
        input  req0, req1, addr0, addr1, wdata0, wdata1, we0, we1,
        input  mem_ready, mem_rdata,
        output gnt0, gnt1, done0, done1, rdata, timeout_err,
        output sel, mem_req, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        output req0, req1, addr0, addr1, wdata0, wdata1, we0, we1,
        output mem_ready, mem_rdata,
        input  gnt0, gnt1, done0, done1, rdata, timeout_err,
        input  sel, mem_req, mem_we, mem_addr, mem_wdata
    );

endinterface

// File: rtl/mux2_1.sv
// Two-input word multiplexer.
module mux2_1 #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] d0,
    input  logic [WIDTH-1:0] d1,
    input  logic             sel,
    output logic [WIDTH-1:0] y
);
    assign y = sel ? d1 : d0;
endmodule

// File: rtl/mem_arbiter2.sv
// Round-robin owner of the shared memory port: fetch (0) vs load/store (1).
module mem_arbiter2
    import nanolada_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int TIMEOUT = 15
) (
    input logic           clk,
    input logic           rst_n,
    mem_arbiter2_if.master bus
);
    localparam int CW = $clog2(TIMEOUT + 1);

    arb_state_t       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             last_q, last_d;
    logic             sel_q, sel_d;
    logic             gnt0_q, gnt0_d, gnt1_q, gnt1_d;
    logic             done0_q, done0_d, done1_q, done1_d;
    logic             mreq_q, mreq_d, mwe_q, mwe_d;
    logic             terr_q, terr_d;
    logic [WIDTH-1:0] rdata_q, rdata_d;
    logic             win;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            last_q  <= REQ_MEM;
            sel_q   <= 1'b0;
            gnt0_q  <= 1'b0;
            gnt1_q  <= 1'b0;
            done0_q <= 1'b0;
            done1_q <= 1'b0;
            mreq_q  <= 1'b0;
            mwe_q   <= 1'b0;
            terr_q  <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
            sel_q   <= sel_d;
            gnt0_q  <= gnt0_d;
            gnt1_q  <= gnt1_d;
            done0_q <= done0_d;
            done1_q <= done1_d;
            mreq_q  <= mreq_d;
            mwe_q   <= mwe_d;
            terr_q  <= terr_d;
            rdata_q <= rdata_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        last_d  = last_q;
        sel_d   = sel_q;
        gnt0_d  = gnt0_q;
        gnt1_d  = gnt1_q;
        done0_d = 1'b0;
        done1_d = 1'b0;
        mreq_d  = mreq_q;
        mwe_d   = mwe_q;
        terr_d  = 1'b0;
        rdata_d = rdata_q;
        win     = REQ_IF;

        unique case (state_q)
            S_IDLE: begin
                // A tie goes to whoever was not served last.
                if (bus.req0 && bus.req1) win = ~last_q;
                else if (bus.req1)        win = REQ_MEM;
                else                      win = REQ_IF;
                if (bus.req0 || bus.req1) begin
                    state_d = S_BUSY;
                    sel_d   = win;
                    gnt0_d  = (win == REQ_IF);
                    gnt1_d  = (win == REQ_MEM);
                    mreq_d  = 1'b1;
                    mwe_d   = (win == REQ_MEM) ? bus.we1 : bus.we0;
                    cnt_d   = '0;
                    last_d  = win;
                end
            end
            S_BUSY: begin
                if (bus.mem_ready || cnt_q == CW'(TIMEOUT - 1)) begin
                    state_d = S_IDLE;
                    done0_d = (sel_q == REQ_IF);
                    done1_d = (sel_q == REQ_MEM);
                    terr_d  = ~bus.mem_ready;
                    rdata_d = (bus.mem_ready && !mwe_q) ? bus.mem_rdata : '0;
                    gnt0_d  = 1'b0;
                    gnt1_d  = 1'b0;
                    mreq_d  = 1'b0;
                    mwe_d   = 1'b0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign bus.gnt0        = gnt0_q;
    assign bus.gnt1        = gnt1_q;
    assign bus.done0       = done0_q;
    assign bus.done1       = done1_q;
    assign bus.rdata       = rdata_q;
    assign bus.timeout_err = terr_q;
    assign bus.sel         = sel_q;
    assign bus.mem_req     = mreq_q;
    assign bus.mem_we      = mwe_q;

    mux2_1 #(.WIDTH(WIDTH)) u_addr_mux (
        .d0  (bus.addr0),
        .d1  (bus.addr1),
        .sel (sel_q),
        .y   (bus.mem_addr)
    );

    mux2_1 #(.WIDTH(WIDTH)) u_wdata_mux (
        .d0  (bus.wdata0),
        .d1  (bus.wdata1),
        .sel (sel_q),
        .y   (bus.mem_wdata)
    );

endmodule

// File: tb/tb_mem_arbiter2.sv
// Directed bench for mem_arbiter2 with hand-computed expectations.
module tb_mem_arbiter2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    mem_arbiter2_if #(.WIDTH(32)) bus ();

    mem_arbiter2 #(.WIDTH(32), .TIMEOUT(15)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        bus.req0 = 0; bus.req1 = 0;
        bus.we0 = 0; bus.we1 = 0;
        bus.addr0 = 32'h0; bus.addr1 = 32'h0;
        bus.wdata0 = 32'h0; bus.wdata1 = 32'h0;
        bus.mem_ready = 0; bus.mem_rdata = 32'h0;
    endtask

    task automatic do_reset;
        rst_n = 0;
        tick;
        tick;
        rst_n = 1;
    endtask

    task automatic test_reset;
        idle_inputs();
        bus.addr0 = 32'h1111;
        bus.addr1 = 32'h2222;
        do_reset();
        checks++;
        if ({bus.gnt0, bus.gnt1, bus.done0, bus.done1} !== 4'b0) begin
            errors++;
            $display("FAIL reset_gnt_done got %b%b%b%b exp 0000",
                     bus.gnt0, bus.gnt1, bus.done0, bus.done1);
        end
        checks++;
        if ({bus.sel, bus.mem_req, bus.mem_we, bus.timeout_err} !== 4'b0) begin
            errors++;
            $display("FAIL reset_ctl got %b%b%b%b exp 0000",
                     bus.sel, bus.mem_req, bus.mem_we, bus.timeout_err);
        end
        checks++;
        if (bus.rdata !== 32'h0) begin
            errors++;
            $display("FAIL reset_rdata got %h exp 0", bus.rdata);
        end
        checks++;
        if (bus.mem_addr !== 32'h1111) begin
            errors++;
            $display("FAIL reset_addr got %h exp 1111", bus.mem_addr);
        end
        bus.addr0 = 0;
        bus.addr1 = 0;
    endtask

    task automatic test_single_read;
        bus.req0 = 1;
        bus.addr0 = 32'h100;
        bus.we0 = 0;
        tick;
        checks++;
        if ({bus.sel, bus.mem_req} !== 2'b01 || bus.mem_addr !== 32'h100) begin
            errors++;
            $display("FAIL read_grant got sel=%b mreq=%b addr=%h exp 0 1 100",
                     bus.sel, bus.mem_req, bus.mem_addr);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (bus.gnt0 !== 1'b1 || bus.done0 !== 1'b0) begin
                errors++;
                $display("FAIL read_busy%0d got gnt0=%b done0=%b exp 1 0",
                         i, bus.gnt0, bus.done0);
            end
            if (i == 3) begin
                bus.mem_ready = 1;
                bus.mem_rdata = 32'hDEADBEEF;
            end
            tick;
        end
        checks++;
        if (bus.done0 !== 1'b1 || bus.gnt0 !== 1'b0 || bus.done1 !== 1'b0) begin
            errors++;
            $display("FAIL read_done got done0=%b gnt0=%b done1=%b exp 1 0 0",
                     bus.done0, bus.gnt0, bus.done1);
        end
        checks++;
        if (bus.rdata !== 32'hDEADBEEF || bus.timeout_err !== 1'b0) begin
            errors++;
            $display("FAIL read_rdata got %h terr=%b exp deadbeef 0",
                     bus.rdata, bus.timeout_err);
        end
        bus.req0 = 0;
        bus.mem_ready = 0;
        tick;
        checks++;
        if (bus.done0 !== 1'b0 || bus.gnt0 !== 1'b0 || bus.mem_req !== 1'b0) begin
            errors++;
            $display("FAIL read_after got done0=%b gnt0=%b mreq=%b exp 0 0 0",
                     bus.done0, bus.gnt0, bus.mem_req);
        end
    endtask

    task automatic test_fairness;
        int o;
        idle_inputs();
        do_reset();
        bus.addr0 = 32'hA0;
        bus.addr1 = 32'hB0;
        bus.req0 = 1;
        bus.req1 = 1;
        bus.mem_ready = 1;
        bus.mem_rdata = 32'hC0C0;
        for (int j = 0; j < 8; j++) begin
            tick;
            o = (j / 2) % 2;
            checks++;
            if (bus.gnt0 && bus.gnt1) begin
                errors++;
                $display("FAIL fair_both%0d got gnt0=1 gnt1=1 exp not both", j);
            end
            if (j % 2 == 0) begin
                checks++;
                if (bus.gnt1 !== o[0] || bus.gnt0 !== ~o[0] || bus.sel !== o[0]) begin
                    errors++;
                    $display("FAIL fair_gnt%0d got g0=%b g1=%b sel=%b exp owner %0d",
                             j, bus.gnt0, bus.gnt1, bus.sel, o);
                end
                checks++;
                if (bus.mem_addr !== (o[0] ? 32'hB0 : 32'hA0)) begin
                    errors++;
                    $display("FAIL fair_addr%0d got %h exp owner %0d addr",
                             j, bus.mem_addr, o);
                end
            end else begin
                checks++;
                if (bus.done1 !== o[0] || bus.done0 !== ~o[0] ||
                    bus.rdata !== 32'hC0C0) begin
                    errors++;
                    $display("FAIL fair_done%0d got d0=%b d1=%b rd=%h exp owner %0d c0c0",
                             j, bus.done0, bus.done1, bus.rdata, o);
                end
            end
        end
        idle_inputs();
        tick;
    endtask

    task automatic test_write;
        bus.req1 = 1;
        bus.we1 = 1;
        bus.addr1 = 32'h40;
        bus.wdata1 = 32'h1234;
        bus.addr0 = 32'h999;
        bus.wdata0 = 32'h888;
        bus.mem_rdata = 32'hFFFF_FFFF;
        tick;
        checks++;
        if ({bus.gnt1, bus.gnt0, bus.sel, bus.mem_we} !== 4'b1011) begin
            errors++;
            $display("FAIL wr_grant got g1=%b g0=%b sel=%b we=%b exp 1 0 1 1",
                     bus.gnt1, bus.gnt0, bus.sel, bus.mem_we);
        end
        checks++;
        if (bus.mem_addr !== 32'h40 || bus.mem_wdata !== 32'h1234) begin
            errors++;
            $display("FAIL wr_bus got addr=%h wdata=%h exp 40 1234",
                     bus.mem_addr, bus.mem_wdata);
        end
        bus.req1 = 0;
        tick;
        checks++;
        if (bus.gnt1 !== 1'b1 || bus.mem_we !== 1'b1 || bus.mem_req !== 1'b1) begin
            errors++;
            $display("FAIL wr_hold got g1=%b we=%b mreq=%b exp 1 1 1",
                     bus.gnt1, bus.mem_we, bus.mem_req);
        end
        bus.mem_ready = 1;
        tick;
        checks++;
        if (bus.done1 !== 1'b1 || bus.rdata !== 32'h0 || bus.gnt1 !== 1'b0) begin
            errors++;
            $display("FAIL wr_done got d1=%b rd=%h g1=%b exp 1 0 0",
                     bus.done1, bus.rdata, bus.gnt1);
        end
        idle_inputs();
        tick;
        checks++;
        if (bus.done1 !== 1'b0 || bus.sel !== 1'b1) begin
            errors++;
            $display("FAIL wr_idle got d1=%b sel=%b exp 0 1", bus.done1, bus.sel);
        end
    endtask

    task automatic test_timeout;
        bus.req0 = 1;
        bus.mem_rdata = 32'h55;
        tick;
        for (int c = 1; c <= 15; c++) begin
            checks++;
            if (bus.gnt0 !== 1'b1 || bus.done0 !== 1'b0) begin
                errors++;
                $display("FAIL to_busy%0d got g0=%b d0=%b exp 1 0",
                         c, bus.gnt0, bus.done0);
            end
            if (c == 15) bus.req0 = 0;
            tick;
        end
        checks++;
        if ({bus.done0, bus.timeout_err, bus.gnt0} !== 3'b110 ||
            bus.rdata !== 32'h0) begin
            errors++;
            $display("FAIL to_abort got d0=%b terr=%b g0=%b rd=%h exp 1 1 0 0",
                     bus.done0, bus.timeout_err, bus.gnt0, bus.rdata);
        end
        tick;
        checks++;
        if (bus.timeout_err !== 1'b0 || bus.done0 !== 1'b0) begin
            errors++;
            $display("FAIL to_pulse got terr=%b d0=%b exp 0 0",
                     bus.timeout_err, bus.done0);
        end
        bus.req0 = 1;
        tick;
        for (int c = 1; c <= 15; c++) begin
            if (c == 15) begin
                bus.req0 = 0;
                bus.mem_ready = 1;
                bus.mem_rdata = 32'h77;
            end
            tick;
        end
        checks++;
        if ({bus.done0, bus.timeout_err} !== 2'b10 || bus.rdata !== 32'h77) begin
            errors++;
            $display("FAIL to_edge got d0=%b terr=%b rd=%h exp 1 0 77",
                     bus.done0, bus.timeout_err, bus.rdata);
        end
        idle_inputs();
        tick;
    endtask

    task automatic test_reset_mid_busy;
        bus.req1 = 1;
        bus.we1 = 1;
        tick;
        tick;
        rst_n = 0;
        #2;
        checks++;
        if ({bus.gnt1, bus.mem_req, bus.sel, bus.mem_we} !== 4'b0) begin
            errors++;
            $display("FAIL rst_async got g1=%b mreq=%b sel=%b we=%b exp 0000",
                     bus.gnt1, bus.mem_req, bus.sel, bus.mem_we);
        end
        bus.mem_ready = 1;
        tick;
        checks++;
        if ({bus.done0, bus.done1, bus.timeout_err} !== 3'b0) begin
            errors++;
            $display("FAIL rst_nodone got d0=%b d1=%b terr=%b exp 000",
                     bus.done0, bus.done1, bus.timeout_err);
        end
        bus.mem_ready = 0;
        bus.we1 = 0;
        bus.req0 = 1;
        rst_n = 1;
        tick;
        checks++;
        if ({bus.gnt0, bus.gnt1, bus.sel} !== 3'b100) begin
            errors++;
            $display("FAIL rst_first got g0=%b g1=%b sel=%b exp 1 0 0",
                     bus.gnt0, bus.gnt1, bus.sel);
        end
        idle_inputs();
        bus.mem_ready = 1;
        tick;
        checks++;
        if (bus.done0 !== 1'b1 || bus.done1 !== 1'b0) begin
            errors++;
            $display("FAIL rst_done got d0=%b d1=%b exp 1 0", bus.done0, bus.done1);
        end
        bus.mem_ready = 0;
        tick;
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_fairness();
        test_write();
        test_timeout();
        test_reset_mid_busy();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
